rtc_set_ctrl: RTL and testbench
===============================

# rtc_set_ctrl

Parametrised display/set controller for the DS1302 clock path. It sits between the debounced keys and the DS1302 driver, which exposes `rd_*`/`wr_*` BCD buses and a `CH` input. It selects the display page and edits the seven BCD time fields with a per-field cursor. Compared with the first-generation top-level FSM it adds:
- key auto-repeat;
- leap-year-aware day limits, with date clamping;
- an edit timeout;
- a `write_req`/`write_ack` commit handshake.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, clock frequency in Hz. All timer terminal counts derive from it.
- `BLINK_HZ`, 2, blink frequency of the selected field.
- `REPEAT_DELAY_MS`, 500, hold time before the first auto-repeat step.
- `REPEAT_RATE_MS`, 100, period between subsequent auto-repeat steps.
- `EDIT_TIMEOUT_S`, 30, idle time in edit mode before the edit is abandoned.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset, synchronous and active-high.
- `key_mode`, `key_next`, `key_up`, `key_down` in 1 each: one-cycle pulses from `KEY_Debounce` on the press edge.
- `key_up_lvl`, `key_down_lvl` in 1 each: debounced held levels, 1 = held.
- `rd_second`, `rd_minute`, `rd_hour`, `rd_date`, `rd_month`, `rd_week`, `rd_year` in 8 each: BCD values read from the DS1302.
- `write_ack` in 1: driver has latched the `wr_*` buses.
- `wr_second`, `wr_minute`, `wr_hour`, `wr_date`, `wr_month`, `wr_week`, `wr_year` out 8 each: BCD edit buffer.
- `write_req` out 1: commit request.
- `ch` out 1: clock-halt, driven to the DS1302 `CH` bit.
- `page` out 2: display page. 0 = time, 1 = date/week, 2 = year.
- `edit` out 1: 1 in EDIT and COMMIT.
- `field_sel` out 3: index of the field under the cursor.
- `blank` out 1: 1 = blank the selected field this blink phase.

## Operation
States:
- **DISP**:
  - `key_next` advances `page` 0→1→2→0.
  - `key_mode` copies all `rd_*` into `wr_*`, sets `field_sel` to the first field of the current page (0, 3 or 6), and moves to EDIT.
- **EDIT**:
  - `key_next` advances `field_sel` 0→1→…→6→0, and `page` follows the field.
  - `key_up` increments the selected field with wrap; `key_down` decrements with wrap.
  - `key_mode` moves to COMMIT.
  - If `EDIT_TIMEOUT_S` elapses with no key pulse or repeat step, return to DISP with no write.
- **COMMIT**:
  - `write_req` = 1, held until `write_ack` is sampled 1.
  - Then go to DISP with `page` unchanged. All keys are ignored here.

Field ranges (BCD, both nibbles always valid):
- hour (0): 00–23
- minute (1), second (2): 00–59
- month (3): 01–12
- date (4): 01–max
- week (5): 1–7
- year (6): 00–99, meaning 2000–2099

Date maximum:
- 31 for months 1, 3, 5, 7, 8, 10, 12.
- 30 for months 4, 6, 9, 11.
- February is 29 when year mod 4 = 0 (BCD test: tens even and units ∈ {0,4,8}, or tens odd and units ∈ {2,6}); otherwise 28.

Date clamp: when month or year changes and `wr_date` exceeds the new maximum, `wr_date` is set to that maximum on the same edge.

Priority for same-cycle events:
- `key_mode` > `key_next` > up/down.
- `key_up` and `key_down` asserted together cause no change.
- `rst` overrides everything.

Auto-repeat:
- A held up/down level produces its first extra step `REPEAT_DELAY_MS` after the press pulse, then one step every `REPEAT_RATE_MS` while still held.
- Releasing the key, or pressing the other direction, restarts the delay.

Other outputs:
- `ch` = 1 in EDIT and COMMIT.
- `blank` = blink phase AND EDIT. Any key pulse or repeat step forces the phase to visible and restarts the blink counter.

## Timing
- Reset values:
  - state DISP, `page` 0, `field_sel` 0.
  - `edit`, `ch`, `write_req` and `blank` 0.
  - `wr_*` = 8'h00, except `wr_date`, `wr_month` and `wr_week`, which are 8'h01.
  - All timers 0.
- All outputs are registered. A key pulse at edge N is reflected on the outputs after edge N+1, i.e. one cycle of latency.
- Entering EDIT snapshots `rd_*` on the same edge as the state change.
- `write_ack` seen high at edge N gives `write_req` = 0 and DISP after edge N+1. `write_ack` asserted outside COMMIT is ignored.
- `rst` asserted mid-EDIT or mid-COMMIT drops `write_req` and `ch` on the next edge and discards the buffer.
- Blink half-period = `CLK_FREQ/(2*BLINK_HZ)` cycles, exactly.

## Structure
- Package `rtc_pkg` holds:
  - the state enum and field index constants F_HOUR..F_YEAR;
  - the per-field BCD min/max constants;
  - a `days_in_month(month_bcd, year_bcd)` function;
  - BCD increment/decrement-with-wrap functions.
- One sequential sub-module, `key_repeat`, instantiated twice (up and down). It takes the press pulse and the held level, and outputs a step pulse: the press pulse OR the repeat steps. The delay and rate are parameters.

## Test plan
Benches use `CLK_FREQ` = 1000 so that timings are short.
- **Enter and edit:** rd = 23:59:58, 02-29, year 24; `key_mode`, then `key_up` → `wr_hour` 00, `ch` = 1, `field_sel` 0, `write_req` 0.
- **Leap clamp:** at field 6 with date 29, month 02, year 24; `key_up` → `wr_year` 25 and `wr_date` 28 on the same edge. Then `key_down` → year 24 and date stays 28.
- **Repeat:** hold `key_up_lvl` on minute 00 for 850 ms → steps at 0, 500, 600, 700 and 800 ms → `wr_minute` 05. Pulsing up and down together → no change.
- **Commit handshake:** `key_mode` in EDIT → `write_req` held 1 for 20 cycles without ack. `write_ack` at cycle 21 → `write_req` 0 and DISP one edge later; `page` preserved.
- **Timeout:** enter EDIT with no keys for 30 s → DISP, `ch` 0, `write_req` never asserted.
- **Reset mid-commit:** `rst` during COMMIT → next edge: all outputs at reset values, `wr_date` 01.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types, field constants and BCD helpers for the DS1302 display/set controller.
package rtc_pkg;

  typedef enum logic [1:0] {
    StDisp   = 2'd0,
    StEdit   = 2'd1,
    StCommit = 2'd2
  } state_e;

  // Field indices, also the cursor order.
  localparam logic [2:0] F_HOUR   = 3'd0;
  localparam logic [2:0] F_MINUTE = 3'd1;
  localparam logic [2:0] F_SECOND = 3'd2;
  localparam logic [2:0] F_MONTH  = 3'd3;
  localparam logic [2:0] F_DATE   = 3'd4;
  localparam logic [2:0] F_WEEK   = 3'd5;
  localparam logic [2:0] F_YEAR   = 3'd6;

  // Packed as {year, week, date, month, second, minute, hour}.
  localparam logic [6:0][7:0] FIELD_MIN = {8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
  localparam logic [6:0][7:0] FIELD_MAX = {8'h99, 8'h07, 8'h31, 8'h12, 8'h59, 8'h59, 8'h23};
  localparam logic [6:0][7:0] FIELD_RST = FIELD_MIN;

  // Year is 2000-2099, so mod-4 is exact; tested directly on the BCD nibbles.
  function automatic logic is_leap(input logic [7:0] year_bcd);
    logic [3:0] units;
    units = year_bcd[3:0];
    if (year_bcd[4]) return (units == 4'd2) || (units == 4'd6);
    else             return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                               input logic [7:0] year_bcd);
    case (month_bcd)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return is_leap(year_bcd) ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v >= hi)              return lo;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v <= lo)              return hi;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return v - 8'd1;
  endfunction

  function automatic logic [1:0] field_page(input logic [2:0] sel);
    if (sel < F_MONTH)     return 2'd0;
    else if (sel < F_YEAR) return 2'd1;
    else                   return 2'd2;
  endfunction

  function automatic logic [2:0] first_field(input logic [1:0] pg);
    case (pg)
      2'd1:    return F_MONTH;
      2'd2:    return F_YEAR;
      default: return F_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/rtc_set_ctrl_key_repeat.sv
// Auto-repeat for one held key: passes the press pulse through and adds repeat steps.
module key_repeat #(
  parameter int unsigned DELAY_CYC = 500,
  parameter int unsigned RATE_CYC  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic held,
  input  logic restart,
  output logic step
);

  localparam int unsigned MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rate_q, rate_d;
  logic          tick;

  // Count the hold time; first terminal count is the delay, later ones the rate.
  always_comb begin
    cnt_d  = cnt_q;
    rate_d = rate_q;
    tick   = 1'b0;
    if (press || restart || !held) begin
      cnt_d  = '0;
      rate_d = 1'b0;
    end else if (cnt_q == CW'(rate_q ? RATE_CYC - 1 : DELAY_CYC - 1)) begin
      tick   = 1'b1;
      cnt_d  = '0;
      rate_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign step = press | tick;

  // Hold-timer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rate_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Display-page / time-set controller between the debounced keys and the DS1302 driver.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned BLINK_HZ        = 2,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned EDIT_TIMEOUT_S  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_up_lvl,
  input  logic       key_down_lvl,
  input  logic [7:0] rd_second,
  input  logic [7:0] rd_minute,
  input  logic [7:0] rd_hour,
  input  logic [7:0] rd_date,
  input  logic [7:0] rd_month,
  input  logic [7:0] rd_week,
  input  logic [7:0] rd_year,
  input  logic       write_ack,
  output logic [7:0] wr_second,
  output logic [7:0] wr_minute,
  output logic [7:0] wr_hour,
  output logic [7:0] wr_date,
  output logic [7:0] wr_month,
  output logic [7:0] wr_week,
  output logic [7:0] wr_year,
  output logic       write_req,
  output logic       ch,
  output logic [1:0] page,
  output logic       edit,
  output logic [2:0] field_sel,
  output logic       blank
);

  localparam int unsigned DELAY_CYC = (CLK_FREQ / 1000) * REPEAT_DELAY_MS;
  localparam int unsigned RATE_CYC  = (CLK_FREQ / 1000) * REPEAT_RATE_MS;
  localparam int unsigned TMO_CYC   = CLK_FREQ * EDIT_TIMEOUT_S;
  localparam int unsigned HALF_CYC  = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned TW        = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int unsigned BW        = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

  state_e          state_q, state_d;
  logic [6:0][7:0] buf_q, buf_d;
  logic [6:0][7:0] rd_all;
  logic [1:0]      page_d;
  logic [2:0]      sel_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic            up_step, down_step, activity;
  logic [7:0]      fld_max, dim;

  assign rd_all = {rd_year, rd_week, rd_date, rd_month, rd_second, rd_minute, rd_hour};

  assign wr_hour   = buf_q[F_HOUR];
  assign wr_minute = buf_q[F_MINUTE];
  assign wr_second = buf_q[F_SECOND];
  assign wr_month  = buf_q[F_MONTH];
  assign wr_date   = buf_q[F_DATE];
  assign wr_week   = buf_q[F_WEEK];
  assign wr_year   = buf_q[F_YEAR];

  // Pressing the opposite direction restarts this key's repeat delay.
  key_repeat #(
    .DELAY_CYC (DELAY_CYC),
    .RATE_CYC  (RATE_CYC)
  ) u_rep_up (
    .clk     (clk),
    .rst     (rst),
    .press   (key_up),
    .held    (key_up_lvl),
    .restart (key_down),
    .step    (up_step)
  );

  key_repeat #(
    .DELAY_CYC (DELAY_CYC),
    .RATE_CYC  (RATE_CYC)
  ) u_rep_down (
    .clk     (clk),
    .rst     (rst),
    .press   (key_down),
    .held    (key_down_lvl),
    .restart (key_up),
    .step    (down_step)
  );

  assign activity = key_mode | key_next | up_step | down_step;

  // Next state, edit buffer, cursor, edit timeout and blink phase.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    page_d  = page;
    sel_d   = field_sel;
    tmo_d   = '0;
    blink_d = blink_q;
    phase_d = phase_q;
    fld_max = 8'h00;
    dim     = 8'h00;

    unique case (state_q)
      StDisp: begin
        if (key_mode) begin
          buf_d   = rd_all;
          sel_d   = first_field(page);
          state_d = StEdit;
        end else if (key_next) begin
          page_d = (page >= 2'd2) ? 2'd0 : page + 2'd1;
        end
      end
      StEdit: begin
        if (key_mode) begin
          state_d = StCommit;
        end else if (key_next) begin
          sel_d  = (field_sel >= F_YEAR) ? F_HOUR : field_sel + 3'd1;
          page_d = field_page(sel_d);
        end else if (up_step ^ down_step) begin
          fld_max = (field_sel == F_DATE) ? days_in_month(buf_q[F_MONTH], buf_q[F_YEAR])
                                          : FIELD_MAX[field_sel];
          buf_d[field_sel] = up_step ? bcd_inc(buf_q[field_sel], FIELD_MIN[field_sel], fld_max)
                                     : bcd_dec(buf_q[field_sel], FIELD_MIN[field_sel], fld_max);
          // A month/year change may shrink the month; pull the date in on the same edge.
          if (field_sel == F_MONTH || field_sel == F_YEAR) begin
            dim = days_in_month(buf_d[F_MONTH], buf_d[F_YEAR]);
            if (buf_q[F_DATE] > dim) buf_d[F_DATE] = dim;
          end
        end

        if (activity) begin
          tmo_d = '0;
        end else if (tmo_q == TW'(TMO_CYC - 1)) begin
          state_d = StDisp;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCommit: begin
        if (write_ack) state_d = StDisp;
      end
      default: state_d = StDisp;
    endcase

    if (state_d != StEdit || activity) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BW'(HALF_CYC - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StDisp;
      buf_q     <= FIELD_RST;
      page      <= 2'd0;
      field_sel <= F_HOUR;
      tmo_q     <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      edit      <= 1'b0;
      ch        <= 1'b0;
      write_req <= 1'b0;
      blank     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      page      <= page_d;
      field_sel <= sel_d;
      tmo_q     <= tmo_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      edit      <= (state_d != StDisp);
      ch        <= (state_d != StDisp);
      write_req <= (state_d == StCommit);
      blank     <= phase_d & (state_d == StEdit);
    end
  end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Randomised bench for rtc_set_ctrl against a cycle-level behavioural model.
module tb_rtc_set_ctrl;

  localparam int CLK_FREQ = 1000;
  localparam int D        = 500;    // repeat delay, cycles
  localparam int R        = 100;    // repeat rate, cycles
  localparam int TMO      = 30000;  // edit timeout, cycles
  localparam int HALF     = 250;    // blink half period, cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, key_mode, key_next, key_up, key_down, key_up_lvl, key_down_lvl, write_ack;
  logic [7:0] rd_second, rd_minute, rd_hour, rd_date, rd_month, rd_week, rd_year;
  logic [7:0] wr_second, wr_minute, wr_hour, wr_date, wr_month, wr_week, wr_year;
  logic       write_req, ch, edit, blank;
  logic [1:0] page;
  logic [2:0] field_sel;

  rtc_set_ctrl #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_mode     (key_mode),
    .key_next     (key_next),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_up_lvl   (key_up_lvl),
    .key_down_lvl (key_down_lvl),
    .rd_second    (rd_second),
    .rd_minute    (rd_minute),
    .rd_hour      (rd_hour),
    .rd_date      (rd_date),
    .rd_month     (rd_month),
    .rd_week      (rd_week),
    .rd_year      (rd_year),
    .write_ack    (write_ack),
    .wr_second    (wr_second),
    .wr_minute    (wr_minute),
    .wr_hour      (wr_hour),
    .wr_date      (wr_date),
    .wr_month     (wr_month),
    .wr_week      (wr_week),
    .wr_year      (wr_year),
    .write_req    (write_req),
    .ch           (ch),
    .page         (page),
    .edit         (edit),
    .field_sel    (field_sel),
    .blank        (blank)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Model: 0 = display, 1 = editing, 2 = waiting for ack. Fields in plain decimal.
  int m_state, m_page, m_sel, m_last, m_edge;
  int m_f[7];
  int m_anc[2];
  int lo[7] = '{0, 0, 0, 1, 1, 1, 0};
  int hi[7] = '{23, 59, 59, 12, 31, 7, 99};

  function automatic int m_dim(input int month, input int year);
    if (month == 2) return (year % 4 == 0) ? 29 : 28;
    if (month == 4 || month == 6 || month == 9 || month == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] to_bcd(input int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, m_edge);
    end
  endtask

  // Repeat model: steps at D cycles after the last restart point, then every R cycles.
  task automatic rep(input int d, input bit pr, input bit oth, input bit lvl, output bit s);
    int k;
    s = 1'b0;
    if (pr || oth || !lvl) begin
      m_anc[d] = m_edge;
    end else begin
      k = m_edge - m_anc[d];
      s = (k == D) || (k > D && (k - D) % R == 0);
    end
  endtask

  task automatic model_tick();
    bit up_r, dn_r, up_s, dn_s, act;
    int mx, dm;
    m_edge++;
    if (rst) begin
      m_state  = 0;
      m_page   = 0;
      m_sel    = 0;
      m_f      = '{0, 0, 0, 1, 1, 1, 0};
      m_anc[0] = m_edge;
      m_anc[1] = m_edge;
      m_last   = m_edge;
      return;
    end
    rep(0, key_up, key_down, key_up_lvl, up_r);
    rep(1, key_down, key_up, key_down_lvl, dn_r);
    up_s = key_up || up_r;
    dn_s = key_down || dn_r;
    act  = key_mode || key_next || up_s || dn_s;
    case (m_state)
      0: begin
        if (key_mode) begin
          m_f[0] = from_bcd(rd_hour);   m_f[1] = from_bcd(rd_minute);
          m_f[2] = from_bcd(rd_second); m_f[3] = from_bcd(rd_month);
          m_f[4] = from_bcd(rd_date);   m_f[5] = from_bcd(rd_week);
          m_f[6] = from_bcd(rd_year);
          m_sel   = m_page * 3;
          m_state = 1;
          m_last  = m_edge;
        end else if (key_next) begin
          m_page = (m_page + 1) % 3;
        end
      end
      1: begin
        if (key_mode) begin
          m_state = 2;
        end else if (key_next) begin
          m_sel  = (m_sel + 1) % 7;
          m_page = m_sel / 3;
        end else if (up_s != dn_s) begin
          mx = (m_sel == 4) ? m_dim(m_f[3], m_f[6]) : hi[m_sel];
          if (up_s) m_f[m_sel] = (m_f[m_sel] >= mx) ? lo[m_sel] : m_f[m_sel] + 1;
          else      m_f[m_sel] = (m_f[m_sel] <= lo[m_sel]) ? mx : m_f[m_sel] - 1;
          dm = m_dim(m_f[3], m_f[6]);
          if ((m_sel == 3 || m_sel == 6) && m_f[4] > dm) m_f[4] = dm;
        end
        if (act) m_last = m_edge;
        else if (m_edge - m_last == TMO) m_state = 0;
      end
      default: begin
        if (write_ack) m_state = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    key_mode = 1'b0;
    key_next = 1'b0;
    key_up   = 1'b0;
    key_down = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_hour",   int'(wr_hour),   int'(to_bcd(m_f[0])));
      chk("wr_minute", int'(wr_minute), int'(to_bcd(m_f[1])));
      chk("wr_second", int'(wr_second), int'(to_bcd(m_f[2])));
      chk("wr_month",  int'(wr_month),  int'(to_bcd(m_f[3])));
      chk("wr_date",   int'(wr_date),   int'(to_bcd(m_f[4])));
      chk("wr_week",   int'(wr_week),   int'(to_bcd(m_f[5])));
      chk("wr_year",   int'(wr_year),   int'(to_bcd(m_f[6])));
      chk("write_req", int'(write_req), int'(m_state == 2));
      chk("ch",        int'(ch),        int'(m_state != 0));
      chk("edit",      int'(edit),      int'(m_state != 0));
      chk("page",      int'(page),      m_page);
      chk("field_sel", int'(field_sel), m_sel);
      chk("blank",     int'(blank),
          int'(m_state == 1 && ((m_edge - m_last) / HALF) % 2 == 1));
    end
  end

  task automatic pulse_up();
    key_up = 1'b1; key_up_lvl = 1'b1; tick(); key_up_lvl = 1'b0;
  endtask

  task automatic pulse_down();
    key_down = 1'b1; key_down_lvl = 1'b1; tick(); key_down_lvl = 1'b0;
  endtask

  initial begin
    int up_hold, dn_hold, mo, yr;
    up_hold = 0;
    dn_hold = 0;
    rst = 1'b1; key_mode = 1'b0; key_next = 1'b0; key_up = 1'b0; key_down = 1'b0;
    key_up_lvl = 1'b0; key_down_lvl = 1'b0; write_ack = 1'b0;
    rd_hour = 8'h23; rd_minute = 8'h59; rd_second = 8'h58;
    rd_month = 8'h02; rd_date = 8'h29; rd_week = 8'h04; rd_year = 8'h24;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset wr_date", int'(wr_date), 'h01);
    chk("reset wr_hour", int'(wr_hour), 'h00);
    chk("reset edit", int'(edit), 0);

    // Enter edit and bump the hour past 23.
    key_mode = 1'b1; tick();
    pulse_up();
    chk("enter wr_hour", int'(wr_hour), 'h00);
    chk("enter ch", int'(ch), 1);
    chk("enter field_sel", int'(field_sel), 0);
    chk("enter write_req", int'(write_req), 0);

    // Leap-year clamp on the year field.
    repeat (6) begin key_next = 1'b1; tick(); end
    chk("year field_sel", int'(field_sel), 6);
    chk("year page", int'(page), 2);
    pulse_up();
    chk("leap wr_year", int'(wr_year), 'h25);
    chk("leap wr_date", int'(wr_date), 'h28);
    pulse_down();
    chk("unleap wr_year", int'(wr_year), 'h24);
    chk("unleap wr_date", int'(wr_date), 'h28);

    // Auto-repeat on the minute field.
    key_next = 1'b1; tick();
    key_next = 1'b1; tick();
    pulse_up();
    chk("minute wrap", int'(wr_minute), 'h00);
    key_up = 1'b1; key_up_lvl = 1'b1; tick();
    repeat (849) tick();
    key_up_lvl = 1'b0; tick();
    chk("repeat wr_minute", int'(wr_minute), 'h05);
    key_up = 1'b1; key_down = 1'b1; key_up_lvl = 1'b1; key_down_lvl = 1'b1; tick();
    key_up_lvl = 1'b0; key_down_lvl = 1'b0; tick();
    chk("up+down wr_minute", int'(wr_minute), 'h05);

    // Commit handshake.
    key_mode = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin
      chk("commit hold", int'(write_req), 1);
      tick();
    end
    chk("commit hold", int'(write_req), 1);
    write_ack = 1'b1; tick(); write_ack = 1'b0;
    chk("ack write_req", int'(write_req), 0);
    chk("ack edit", int'(edit), 0);
    chk("ack page", int'(page), 0);

    // Edit timeout.
    key_mode = 1'b1; tick();
    repeat (TMO - 1) tick();
    chk("pre-timeout edit", int'(edit), 1);
    tick();
    chk("timeout edit", int'(edit), 0);
    chk("timeout ch", int'(ch), 0);
    chk("timeout write_req", int'(write_req), 0);

    // Reset in the middle of a commit.
    key_mode = 1'b1; tick();
    pulse_up();
    key_mode = 1'b1; tick();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst write_req", int'(write_req), 0);
    chk("rst ch", int'(ch), 0);
    chk("rst wr_date", int'(wr_date), 'h01);
    chk("rst wr_month", int'(wr_month), 'h01);
    chk("rst field_sel", int'(field_sel), 0);

    // Randomised traffic.
    for (int c = 0; c < 8000; c++) begin
      mo = int'($urandom_range(1, 12));
      yr = int'($urandom_range(0, 99));
      rd_hour   = to_bcd(int'($urandom_range(0, 23)));
      rd_minute = to_bcd(int'($urandom_range(0, 59)));
      rd_second = to_bcd(int'($urandom_range(0, 59)));
      rd_month  = to_bcd(mo);
      rd_year   = to_bcd(yr);
      rd_date   = to_bcd(int'($urandom_range(1, m_dim(mo, yr))));
      rd_week   = to_bcd(int'($urandom_range(1, 7)));
      key_mode  = ($urandom_range(0, 149) == 0);
      key_next  = ($urandom_range(0, 29) == 0);
      write_ack = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 2999) == 0);
      if (up_hold > 0) begin
        up_hold--;
        if (up_hold == 0) key_up_lvl = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        key_up = 1'b1; key_up_lvl = 1'b1; up_hold = int'($urandom_range(1, 1200));
      end
      if (dn_hold > 0) begin
        dn_hold--;
        if (dn_hold == 0) key_down_lvl = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        key_down = 1'b1; key_down_lvl = 1'b1; dn_hold = int'($urandom_range(1, 1200));
      end
      tick();
    end
    rst = 1'b0; key_up_lvl = 1'b0; key_down_lvl = 1'b0; write_ack = 1'b0;
    repeat (4) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
